// File: rtl/mask_gen_range.sv
// rtl/mask_gen_range.sv - thermometer/range mask generator built one count bit per cycle
// Every mode reduces to rfill(n1) & ~rfill(n0), optionally inverted at the end.
module mask_gen_range #(
  parameter int WIDTH = 512,
  localparam int CW = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_trig,
  input  logic [1:0]       i_mode,
  input  logic [CW-1:0]    i_a,
  input  logic [CW-1:0]    i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [WIDTH-1:0] o_mask
);
  localparam int KW = $clog2(CW);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [1:0] MODE_LEFT      = 2'b00;
  localparam logic [1:0] MODE_RIGHT     = 2'b01;
  localparam logic [1:0] MODE_RANGE_INV = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_BUILD, S_COMBINE, S_DONE} state_t;
  state_t state, state_nx;

  logic [CW-1:0]    n1, n0, n1_in, n0_in;
  logic [WIDTH-1:0] p_q, q_q, ones_w;
  logic [KW-1:0]    k;
  logic [CW-1:0]    w;
  logic             inv;
  logic             req_ok;

  always_comb begin
    n1_in  = '0;
    n0_in  = '0;
    req_ok = 1'b0;
    case (i_mode)
      MODE_LEFT: begin
        n1_in  = FULL;
        n0_in  = FULL - i_a;
        req_ok = (i_a <= FULL);
      end
      MODE_RIGHT: begin
        n1_in  = i_a;
        n0_in  = '0;
        req_ok = (i_a <= FULL);
      end
      default: begin
        n1_in  = i_b + CW'(1);
        n0_in  = i_a;
        req_ok = (i_a <= i_b) && (i_b < FULL);
      end
    endcase
  end

  // A shift by w == WIDTH clears the register, so the fill term alone makes it all ones.
  assign w      = CW'(1) << k;
  assign ones_w = ~({WIDTH{1'b1}} << w);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (i_trig) begin
          state_nx = req_ok ? S_BUILD : S_DONE;
        end
      end
      S_BUILD: begin
        if (!i_trig) begin
          state_nx = S_IDLE;
        end else if (k == '0) begin
          state_nx = S_COMBINE;
        end
      end
      S_COMBINE: state_nx = i_trig ? S_DONE : S_IDLE;
      S_DONE: begin
        if (!i_trig) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      n1     <= '0;
      n0     <= '0;
      p_q    <= '0;
      q_q    <= '0;
      k      <= '0;
      inv    <= 1'b0;
      o_err  <= 1'b0;
      o_mask <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_trig) begin
            n1    <= n1_in;
            n0    <= n0_in;
            inv   <= (i_mode == MODE_RANGE_INV);
            o_err <= !req_ok;
            p_q   <= '0;
            q_q   <= '0;
            k     <= KW'(CW - 1);
            if (!req_ok) begin
              o_mask <= '0;
            end
          end
        end
        S_BUILD: begin
          if (i_trig) begin
            if (n1[k]) begin
              p_q <= (p_q << w) | ones_w;
            end
            if (n0[k]) begin
              q_q <= (q_q << w) | ones_w;
            end
            k <= k - KW'(1);
          end
        end
        S_COMBINE: begin
          if (i_trig) begin
            o_mask <= inv ? ~(p_q & ~q_q) : (p_q & ~q_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (state == S_BUILD) || (state == S_COMBINE);
  assign o_done = (state == S_DONE) && i_trig;

endmodule

// File: tb/tb_mask_gen_range.sv
// tb/tb_mask_gen_range.sv - bench for mask_gen_range: vector table, corner sequences, random vs model
module tb_mask_gen_range;
  localparam int W  = 512;
  localparam int CW = $clog2(W) + 1;

  logic          clk;
  logic          rstn;
  logic          trig;
  logic [1:0]    mode;
  logic [CW-1:0] a_in;
  logic [CW-1:0] b_in;
  logic          busy;
  logic          done;
  logic          err;
  logic [W-1:0]  mask;

  int passed = 0;
  int total  = 0;

  mask_gen_range #(.WIDTH(W)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .i_trig (trig),
    .i_mode (mode),
    .i_a    (a_in),
    .i_b    (b_in),
    .o_busy (busy),
    .o_done (done),
    .o_err  (err),
    .o_mask (mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]   mode;
    int           a;
    int           b;
    logic [W-1:0] mask;
    logic         err;
    int           hold;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: the mask written straight from the per-bit definition of each mode.
  task automatic model(input logic [1:0] m, input int a, input int b,
                       output logic [W-1:0] mk, output logic er);
    mk = '0;
    if (m < 2) er = (a > W);
    else       er = (a > b) || (b > W - 1);
    if (!er) begin
      for (int i = 0; i < W; i++) begin
        case (m)
          2'd0:    mk[i] = (i >= W - a);
          2'd1:    mk[i] = (i < a);
          default: mk[i] = (i >= a) && (i <= b);
        endcase
      end
      if (m == 2'd3) mk = ~mk;
    end
  endtask

  task automatic run_req(input string nm, input logic [1:0] m, input int a, input int b,
                         input logic [W-1:0] emask, input logic eerr, input int hold);
    int   lat;
    logic busy0, err0, stable;
    @(negedge clk);
    trig = 1'b1;
    mode = m;
    a_in = CW'(a);
    b_in = CW'(b);
    lat = 0;
    busy0 = 1'b0;
    err0 = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        busy0 = busy;
        err0  = err;
        mode  = 2'($urandom);
        a_in  = CW'($urandom);
        b_in  = CW'($urandom);
      end
    end while (!done && lat < 40);
    chk({nm, " latency"}, W'(lat), W'(eerr ? 1 : CW + 2));
    chk({nm, " busy_after_accept"}, W'(busy0), W'(!eerr));
    chk({nm, " err_after_accept"}, W'(err0), W'(eerr));
    chk({nm, " mask"}, mask, emask);
    chk({nm, " err"}, W'(err), W'(eerr));
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!done || mask !== emask) stable = 1'b0;
    end
    if (hold > 0) chk({nm, " hold_stable"}, W'(stable), W'(1));
    trig = 1'b0;
    #1;
    chk({nm, " release"}, W'(done), W'(0));
  endtask

  logic [W-1:0] em;
  logic         ee;
  logic         saw_done;
  int           ra, rb;
  logic [1:0]   rm;

  initial begin
    vecs[0]  = '{2'd1, 5,   0,   W'(32'h1F),        1'b0, 3};
    vecs[1]  = '{2'd0, 3,   0,   {3'b111, 509'd0},  1'b0, 0};
    vecs[2]  = '{2'd0, 512, 0,   {W{1'b1}},         1'b0, 0};
    vecs[3]  = '{2'd0, 0,   0,   '0,                1'b0, 0};
    vecs[4]  = '{2'd2, 4,   7,   W'(32'hF0),        1'b0, 0};
    vecs[5]  = '{2'd2, 511, 511, {1'b1, 511'd0},    1'b0, 0};
    vecs[6]  = '{2'd3, 0,   510, {1'b1, 511'd0},    1'b0, 0};
    vecs[7]  = '{2'd2, 8,   4,   '0,                1'b1, 0};
    vecs[8]  = '{2'd1, 1,   0,   W'(32'h1),         1'b0, 0};
    vecs[9]  = '{2'd1, 513, 0,   '0,                1'b1, 0};
    vecs[10] = '{2'd3, 3,   512, '0,                1'b1, 0};
    vecs[11] = '{2'd1, 512, 0,   {W{1'b1}},         1'b0, 1};

    rstn = 1'b0;
    trig = 1'b0;
    mode = '0;
    a_in = '0;
    b_in = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    chk("reset mask", mask, '0);
    chk("reset err", W'(err), W'(0));
    chk("reset busy", W'(busy), W'(0));
    chk("reset done", W'(done), W'(0));

    for (int i = 0; i < 12; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].mode, vecs[i].a, vecs[i].b,
              vecs[i].mask, vecs[i].err, vecs[i].hold);
    end

    // Abort at BUILD step 4 leaves the previous result in place.
    run_req("pre_abort", 2'd1, 5, 0, W'(32'h1F), 1'b0, 0);
    @(negedge clk);
    trig = 1'b1;
    mode = 2'd0;
    a_in = CW'(3);
    b_in = '0;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    trig = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort no_done", W'(saw_done), W'(0));
    chk("abort busy", W'(busy), W'(0));
    chk("abort mask", mask, W'(32'h1F));
    chk("abort err", W'(err), W'(0));
    run_req("retrigger", 2'd0, 3, 0, {3'b111, 509'd0}, 1'b0, 0);

    // A reset pulse that misses every rising edge changes nothing.
    @(negedge clk);
    #1 rstn = 1'b0;
    #2 rstn = 1'b1;
    @(negedge clk);
    chk("glitch mask", mask, {3'b111, 509'd0});

    // Reset in the middle of a build.
    @(negedge clk);
    trig = 1'b1;
    mode = 2'd1;
    a_in = CW'(7);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("midreset mask", mask, '0);
    chk("midreset err", W'(err), W'(0));
    chk("midreset busy", W'(busy), W'(0));
    chk("midreset done", W'(done), W'(0));
    rstn = 1'b1;
    trig = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      rm = 2'($urandom_range(0, 3));
      if (rm < 2) begin
        ra = int'($urandom_range(0, 520));
        rb = int'($urandom_range(0, 1023));
      end else begin
        rb = int'($urandom_range(0, 520));
        ra = int'($urandom_range(0, rb + 3));
      end
      model(rm, ra, rb, em, ee);
      run_req($sformatf("rand%0d m%0d a%0d b%0d", i, rm, ra, rb), rm, ra, rb, em, ee, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
